dbu_run_ctrl: RTL and testbench
===============================

// Module: dbu_run_ctrl
// PURPOSE
//   Run-control sequencer placed between the DBU front panel and the CPU.
//   - Turns the succ switch and step button into a CPU clock-enable (cpu_en): free-run or single-step.
//   - Conditions the inc/dec buttons into a wrapping inspection address for memory or register file.
//   - Keeps a wrapping count of enabled CPU cycles for the display path.
// PARAMETERS
//   DEB_CYCLES  4   consecutive stable samples required before a debounced level changes (>=1)
//   ADDR_W      8   memory inspection address width
//   RF_AW       5   register-file inspection address width (RF_AW <= ADDR_W)
//   CNT_W       16  width of executed-cycle counter
// PORTS
//   clk       in   1       system clock, all logic on rising edge
//   rst       in   1       synchronous reset, active-low (0 = reset)
//   succ      in   1       run switch, level: 1 = continuous run
//   step      in   1       single-step button, raw/bouncy
//   inc       in   1       address increment button, raw/bouncy
//   dec       in   1       address decrement button, raw/bouncy
//   m_rf      in   1       inspection target: 1 = memory, 0 = register file
//   cpu_en    out  1       CPU clock enable
//   run_state out  2       FSM state: 00 HALT, 01 RUN, 10 STEP
//   view_addr out  ADDR_W  inspection address
//   exec_cnt  out  CNT_W   number of cycles with cpu_en=1, wraps
// BEHAVIOUR
//   Reset (rst=0 at a rising edge)
//   - state=HALT; cpu_en=0; view_addr=0; exec_cnt=0.
//   - All synchronizers, debounce counters and edge registers are cleared.
//   - Reset mid-RUN/STEP: cpu_en is 0 from the next edge on.
//   Input conditioning
//   - Every input (succ, step, inc, dec, m_rf) passes through a 2-flop synchronizer.
//   - succ and m_rf are used as synchronized levels; they are not debounced.
//   - step, inc and dec each have their own debouncer.
//   - Debouncer: the debounced level flips only after DEB_CYCLES consecutive synchronized
//     samples differ from it; any sample equal to the current level clears the counter.
//   - Rising edge of a debounced level -> 1-cycle pulse (step_p / inc_p / dec_p).
//   - Latency: raw input held high from before edge N -> pulse high exactly in the cycle
//     after edge N+2+DEB_CYCLES.
//   - Holding a button produces one pulse only. Bounces shorter than DEB_CYCLES produce no pulse.
//   FSM (registered)
//   - HALT: succ_s=1 -> RUN; else if step_p -> STEP. If both happen together, succ wins.
//   - RUN:  succ_s=0 -> HALT; step_p is ignored.
//   - STEP: unconditionally -> HALT after one cycle, so exactly one cpu_en cycle per step.
//   - cpu_en = (state==RUN) | (state==STEP), decoded from the state register, no extra latency.
//   - run_state mirrors the state encoding; value 11 is never reached and decodes as HALT.
//   exec_cnt
//   - +1 on every edge where cpu_en=1; FFFF -> 0000 wraps silently.
//   view_addr
//   - inc_p alone: +1. dec_p alone: -1. inc_p and dec_p together: no change.
//   - m_rf_s=1 (memory): wraps modulo 2^ADDR_W (FF+1=00, 00-1=FF).
//   - m_rf_s=0 (register file): wraps modulo 2^RF_AW; upper bits held 0 (1F+1=00, 00-1=1F).
//   - A change of m_rf_s (registered copy vs current) clears view_addr to 0 on that edge,
//     overriding inc_p/dec_p.
//   - inc_p/dec_p are ignored while state==RUN.
// TESTING (DEB_CYCLES=4)
//   1. rst=0 two cycles, then rst=1, all inputs 0 -> cpu_en=0, run_state=00, view_addr=00,
//      exec_cnt=0 for 20 cycles.
//   2. step=1 held 20 cycles, succ=0 -> cpu_en high for exactly 1 cycle, starting 8 cycles
//      after the step edge (pulse 7, STEP 8); exec_cnt=1; run_state 10 then 00.
//   3. succ=1 for 30 cycles, then 0 -> cpu_en continuous; exec_cnt=28 +/-0 per synchronizer
//      latency (2-cycle delay in and out); run_state returns to 00.
//   4. m_rf=0, view_addr=00, one clean dec press -> view_addr=1F; then three inc presses -> 02.
//   5. m_rf=1, view_addr=FF, inc press -> 00. Toggle m_rf -> view_addr=00 two cycles later.
//      inc and dec pressed in the same cycle -> no change.
//   6. step toggling every 2 cycles for 20 cycles -> no cpu_en pulse. rst=0 during RUN ->
//      cpu_en=0 and exec_cnt=0 at the next edge.

Source files
------------

// File: rtl/dbu_run_ctrl.sv
// dbu_run_ctrl: run-control sequencer between the DBU front panel and the CPU.
//   Synchronizes the panel inputs, debounces the step/inc/dec buttons into
//   single-cycle pulses, sequences free-run / single-step via a HALT/RUN/STEP
//   FSM, maintains a wrapping inspection address and counts enabled cycles.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   succ       run switch level (1 = continuous run)
//   step       single-step button, raw
//   inc, dec   inspection address buttons, raw
//   m_rf       inspection target (1 = memory, 0 = register file)
//   cpu_en     CPU clock enable, decoded from the state register
//   run_state  FSM state (00 HALT, 01 RUN, 10 STEP)
//   view_addr  inspection address
//   exec_cnt   count of cycles with cpu_en = 1, wraps
module dbu_run_ctrl #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RF_AW      = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              succ,
  input  logic              step,
  input  logic              inc,
  input  logic              dec,
  input  logic              m_rf,
  output logic              cpu_en,
  output logic [1:0]        run_state,
  output logic [ADDR_W-1:0] view_addr,
  output logic [CNT_W-1:0]  exec_cnt
);

  localparam int unsigned DEB_CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_CW-1:0] DEB_LAST = DEB_CW'(DEB_CYCLES - 1);
  localparam logic [ADDR_W-1:0] RF_MASK  = ADDR_W'((64'd1 << RF_AW) - 64'd1);

  // Bit order of the synchronizer vectors
  localparam int unsigned IDX_SUCC = 0;
  localparam int unsigned IDX_MRF  = 4;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t            state;
  logic [4:0]        sync1;
  logic [4:0]        sync2;
  logic              m_rf_q;
  logic [2:0]        btn_p;     // {dec_p, inc_p, step_p}
  logic              succ_s;
  logic              m_rf_s;
  logic              step_p;
  logic              inc_p;
  logic              dec_p;
  logic [ADDR_W-1:0] addr_step;
  logic [ADDR_W-1:0] addr_next;

  assign succ_s = sync2[IDX_SUCC];
  assign m_rf_s = sync2[IDX_MRF];
  assign step_p = btn_p[0];
  assign inc_p  = btn_p[1];
  assign dec_p  = btn_p[2];

  // Per-button debouncer and rising-edge pulse generator (sync2 bits 1..3)
  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic              lvl;
    logic              lvl_q;
    logic              pulse;
    logic [DEB_CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (!rst) begin
        lvl   <= 1'b0;
        lvl_q <= 1'b0;
        pulse <= 1'b0;
        cnt   <= '0;
      end else begin
        lvl_q <= lvl;
        pulse <= lvl & ~lvl_q;
        // Any sample agreeing with the current level restarts the count
        if (sync2[g+1] == lvl) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + DEB_CW'(1);
        end
      end
    end

    assign btn_p[g] = pulse;
  end

  // Address arithmetic: full-width wrap for memory, RF_AW-bit wrap for the RF
  always_comb begin
    addr_step = inc_p ? (view_addr + ADDR_W'(1)) : (view_addr - ADDR_W'(1));
    addr_next = m_rf_s ? addr_step : (addr_step & RF_MASK);
  end

  // Synchronizers, FSM, inspection address and cycle counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      m_rf_q    <= 1'b0;
      state     <= ST_HALT;
      view_addr <= '0;
      exec_cnt  <= '0;
    end else begin
      sync1  <= {m_rf, dec, inc, step, succ};
      sync2  <= sync1;
      m_rf_q <= m_rf_s;

      if (cpu_en) begin
        exec_cnt <= exec_cnt + CNT_W'(1);
      end

      case (state)
        ST_HALT: begin
          if (succ_s) begin
            state <= ST_RUN;
          end else if (step_p) begin
            state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (!succ_s) begin
            state <= ST_HALT;
          end
        end
        default: state <= ST_HALT;
      endcase

      // A target switch restarts inspection from address 0
      if (m_rf_s != m_rf_q) begin
        view_addr <= '0;
      end else if ((state != ST_RUN) && (inc_p ^ dec_p)) begin
        view_addr <= addr_next;
      end
    end
  end

  assign cpu_en    = (state == ST_RUN) || (state == ST_STEP);
  assign run_state = state;

endmodule

// File: tb/tb_dbu_run_ctrl.sv
// tb_dbu_run_ctrl: table-driven vectors, hand sequences for the multi-cycle
// corners, and randomized panel activity against a cycle-level reference model.
module tb_dbu_run_ctrl;

  localparam int unsigned DEB    = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned RF_AW  = 5;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst, succ, step, inc, dec, m_rf;
  logic              cpu_en;
  logic [1:0]        run_state;
  logic [ADDR_W-1:0] view_addr;
  logic [CNT_W-1:0]  exec_cnt;

  dbu_run_ctrl #(
    .DEB_CYCLES(DEB), .ADDR_W(ADDR_W), .RF_AW(RF_AW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .succ(succ), .step(step), .inc(inc), .dec(dec),
    .m_rf(m_rf), .cpu_en(cpu_en), .run_state(run_state),
    .view_addr(view_addr), .exec_cnt(exec_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs reach the logic two edges late; a debounced level flips once the
  // last DEB synchronized samples all disagree with it; pulses follow one edge later.
  int         m_state;   // 0 HALT, 1 RUN, 2 STEP
  int         m_addr;
  int         m_cnt;
  bit [2:0]   m_lvl, m_lvl_d, m_p;   // bit 0 step, 1 inc, 2 dec
  logic [4:0] raw_h[$];              // {m_rf, dec, inc, step, succ} per edge
  logic [2:0] win_h[$];

  task automatic model_reset();
    m_state = 0; m_addr = 0; m_cnt = 0;
    m_lvl = '0; m_lvl_d = '0; m_p = '0;
    raw_h.delete();
    repeat (3) raw_h.push_back(5'd0);
    win_h.delete();
  endtask

  task automatic model_edge(input logic r, input logic [4:0] in_v);
    logic [4:0] s, sp;
    int         old_state, modv;
    bit [2:0]   old_p;
    bit         all_diff;
    if (!r) begin
      model_reset();
    end else begin
      s  = raw_h[raw_h.size()-2];
      sp = raw_h[raw_h.size()-3];
      old_state = m_state;
      old_p     = m_p;
      if (old_state != 0) m_cnt = (m_cnt + 1) % 65536;
      case (old_state)
        0:       m_state = s[0] ? 1 : (old_p[0] ? 2 : 0);
        1:       m_state = s[0] ? 1 : 0;
        default: m_state = 0;
      endcase
      if (s[4] != sp[4]) begin
        m_addr = 0;
      end else if (old_state != 1 && (old_p[1] != old_p[2])) begin
        modv   = s[4] ? 256 : 32;
        m_addr = old_p[1] ? (m_addr + 1) % modv : (m_addr + modv - 1) % modv;
      end
      m_p     = m_lvl & ~m_lvl_d;
      m_lvl_d = m_lvl;
      win_h.push_back(s[3:1]);
      if (win_h.size() > DEB) void'(win_h.pop_front());
      if (win_h.size() == DEB) begin
        for (int b = 0; b < 3; b++) begin
          all_diff = 1'b1;
          foreach (win_h[i]) if (win_h[i][b] == m_lvl[b]) all_diff = 1'b0;
          if (all_diff) m_lvl[b] = ~m_lvl[b];
        end
      end
      raw_h.push_back(in_v);
      while (raw_h.size() > 3) void'(raw_h.pop_front());
    end
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_edge(rst, {m_rf, dec, inc, step, succ});
    #1;
    check("model_cpu_en",    32'(cpu_en),    32'(m_state != 0));
    check("model_run_state", 32'(run_state), 32'(m_state));
    check("model_view_addr", 32'(view_addr), 32'(m_addr));
    check("model_exec_cnt",  32'(exec_cnt),  32'(m_cnt));
  endtask

  task automatic set_in(input logic r, input logic su, input logic st,
                        input logic in_b, input logic de, input logic mr);
    rst = r; succ = su; step = st; inc = in_b; dec = de; m_rf = mr;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, succ, step, inc, dec, m_rf;
    int          cyc;
    logic        e_en;
    logic [1:0]  e_rs;
    logic [7:0]  e_addr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic su, input logic st, input logic in_b,
                     input logic de, input logic mr, input int cyc, input logic en,
                     input logic [1:0] rs, input logic [7:0] a, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.succ = su; v.step = st; v.inc = in_b; v.dec = de; v.m_rf = mr;
    v.cyc = cyc; v.e_en = en; v.e_rs = rs; v.e_addr = a; v.e_cnt = c;
    tbl.push_back(v);
  endtask

  int         run_len[5];
  logic [4:0] cur;

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();

    //  rst su st in de mr cyc  en rs     addr   cnt
    add(0, 0, 0, 0, 0, 0,  2,  0, 2'b00, 8'h00, 16'd0);   // reset
    add(1, 0, 0, 0, 0, 0, 20,  0, 2'b00, 8'h00, 16'd0);   // idle
    add(1, 0, 0, 0, 1, 0, 12,  0, 2'b00, 8'h1F, 16'd0);   // RF dec wraps
    add(1, 0, 0, 0, 0, 0, 10,  0, 2'b00, 8'h1F, 16'd0);
    add(1, 0, 0, 1, 0, 0, 12,  0, 2'b00, 8'h00, 16'd0);   // RF inc wraps
    add(1, 0, 0, 0, 0, 0, 10,  0, 2'b00, 8'h00, 16'd0);
    add(1, 0, 0, 1, 0, 0, 12,  0, 2'b00, 8'h01, 16'd0);
    add(1, 0, 0, 0, 0, 0, 10,  0, 2'b00, 8'h01, 16'd0);
    add(1, 0, 0, 1, 0, 0, 12,  0, 2'b00, 8'h02, 16'd0);
    add(1, 0, 0, 0, 0, 0, 10,  0, 2'b00, 8'h02, 16'd0);
    add(1, 0, 1, 0, 0, 0, 20,  0, 2'b00, 8'h02, 16'd1);   // held step: one cycle
    add(1, 0, 0, 0, 0, 0, 10,  0, 2'b00, 8'h02, 16'd1);
    add(1, 1, 0, 0, 0, 0,  5,  1, 2'b01, 8'h02, 16'd3);   // RUN after 2-edge sync
    add(1, 1, 0, 0, 0, 0, 25,  1, 2'b01, 8'h02, 16'd28);
    add(1, 0, 0, 0, 0, 0, 10,  0, 2'b00, 8'h02, 16'd31);  // 30 run cycles total
    add(1, 0, 0, 0, 0, 1,  6,  0, 2'b00, 8'h00, 16'd31);  // target switch clears
    add(1, 0, 0, 0, 1, 1, 12,  0, 2'b00, 8'hFF, 16'd31);  // mem dec wraps
    add(1, 0, 0, 0, 0, 1, 10,  0, 2'b00, 8'hFF, 16'd31);
    add(1, 0, 0, 1, 0, 1, 12,  0, 2'b00, 8'h00, 16'd31);  // mem inc wraps
    add(1, 0, 0, 0, 0, 1, 10,  0, 2'b00, 8'h00, 16'd31);
    add(1, 0, 0, 1, 1, 1, 12,  0, 2'b00, 8'h00, 16'd31);  // inc+dec cancel
    add(1, 0, 0, 0, 0, 1, 10,  0, 2'b00, 8'h00, 16'd31);
    add(1, 0, 0, 0, 1, 1, 12,  0, 2'b00, 8'hFF, 16'd31);
    add(1, 0, 0, 0, 0, 1, 10,  0, 2'b00, 8'hFF, 16'd31);
    add(1, 0, 0, 0, 0, 0,  6,  0, 2'b00, 8'h00, 16'd31);  // switch back clears
    add(1, 1, 0, 0, 0, 0, 10,  1, 2'b01, 8'h00, 16'd38);
    add(1, 1, 0, 1, 0, 0, 12,  1, 2'b01, 8'h00, 16'd50);  // inc ignored in RUN
    add(0, 1, 0, 0, 0, 0,  1,  0, 2'b00, 8'h00, 16'd0);   // reset mid-RUN
    add(1, 0, 0, 0, 0, 0, 10,  0, 2'b00, 8'h00, 16'd0);

    foreach (tbl[i]) begin
      set_in(tbl[i].rst, tbl[i].succ, tbl[i].step, tbl[i].inc, tbl[i].dec, tbl[i].m_rf);
      repeat (tbl[i].cyc) tick();
      check($sformatf("vec%0d_cpu_en", i),    32'(cpu_en),    32'(tbl[i].e_en));
      check($sformatf("vec%0d_run_state", i), 32'(run_state), 32'(tbl[i].e_rs));
      check($sformatf("vec%0d_view_addr", i), 32'(view_addr), 32'(tbl[i].e_addr));
      check($sformatf("vec%0d_exec_cnt", i),  32'(exec_cnt),  32'(tbl[i].e_cnt));
    end

    // Step latency: STEP visible in the cycle after the 8th edge with step high
    set_in(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("step_lat_quiet", 32'(cpu_en), 32'd0);
    end
    tick();
    check("step_lat_en",    32'(cpu_en),    32'd1);
    check("step_lat_state", 32'(run_state), 32'd2);
    tick();
    check("step_after_en",    32'(cpu_en),    32'd0);
    check("step_after_state", 32'(run_state), 32'd0);
    check("step_after_cnt",   32'(exec_cnt),  32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("step_hold_quiet", 32'(cpu_en), 32'd0);
    end
    set_in(1, 0, 0, 0, 0, 0);
    repeat (10) tick();

    // Bouncing step shorter than the debounce window never fires
    for (int i = 0; i < 20; i++) begin
      step = ((i / 2) % 2) == 0;
      tick();
      check("bounce_quiet", 32'(cpu_en), 32'd0);
    end
    set_in(1, 0, 0, 0, 0, 0);
    repeat (10) tick();
    check("bounce_cnt", 32'(exec_cnt), 32'd1);

    // Reset while running
    set_in(1, 1, 0, 0, 0, 0);
    repeat (6) tick();
    check("run_state_pre_rst", 32'(run_state), 32'd1);
    set_in(0, 1, 0, 0, 0, 0);
    tick();
    check("rst_run_en",  32'(cpu_en),   32'd0);
    check("rst_run_cnt", 32'(exec_cnt), 32'd0);
    set_in(1, 0, 0, 0, 0, 0);
    repeat (4) tick();

    // Randomized panel activity with mixed bounce lengths
    cur = '0;
    foreach (run_len[i]) run_len[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (run_len[i] == 0) begin
          cur[i] = ~cur[i];
          if (i == 0)      run_len[i] = int'($urandom_range(5, 60));
          else if (i == 4) run_len[i] = int'($urandom_range(4, 80));
          else             run_len[i] = int'($urandom_range(1, 14));
        end
        run_len[i]--;
      end
      set_in(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1,
             cur[0], cur[1], cur[2], cur[3], cur[4]);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
